// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-requester round-robin arbiter in front of the shared register-bus
//   core chain. Requester A (UART bridge_rx path) and requester B (second
//   on-chip master) share one addr/wdata/rw/valid bus. Each issued
//   transaction pushes its requester id into an ordered tag FIFO. Chain
//   responses pop the head id, which routes the response back to the
//   requester that issued it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   a_*_i / a_ready_o     requester A request channel (valid/ready)
//   b_*_i / b_ready_o     requester B request channel (valid/ready)
//   addr_o/wdata_o/rw_o   registered request to the core chain
//   valid_o               one-cycle pulse per issued transaction
//   rdata_i/rw_i/valid_i  response from the end of the chain
//   a_rdata_o/a_rw_o/a_valid_o  response routed to A
//   b_rdata_o/b_rw_o/b_valid_o  response routed to B
//   err_o                 sticky: response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    input  logic                  a_rw_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,

    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    input  logic                  b_rw_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,

    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  rw_o,
    output logic                  valid_o,

    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,

    output logic [DATA_WIDTH-1:0] a_rdata_o,
    output logic                  a_rw_o,
    output logic                  a_valid_o,

    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  b_rw_o,
    output logic                  b_valid_o,

    output logic                  err_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

    // Tag FIFO: one bit per entry holds the requester id (0 = A, 1 = B).
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PW-1:0]              wptr_q, wptr_d;
    logic [PW-1:0]              rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;

    // 1 = B was granted last, so A wins the next tie.
    logic                       last_b_q, last_b_d;
    logic                       err_q, err_d;

    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       rw_q, rw_d;
    logic                       valid_q, valid_d;

    logic [DATA_WIDTH-1:0]      a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                       a_rw_q, a_rw_d, b_rw_q, b_rw_d;
    logic                       a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    logic can_issue, grant_a, grant_b, grant, pop, head_id;

    // Credit comes only from the registered count, so a response popping in
    // the same cycle does not free a slot until the next cycle. Gating with
    // rst_n keeps ready low while reset is held.
    assign can_issue = rst_n && (count_q < FULL);
    assign grant_a   = can_issue & a_valid_i & (~b_valid_i | last_b_q);
    assign grant_b   = can_issue & b_valid_i & (~a_valid_i | ~last_b_q);
    assign grant     = grant_a | grant_b;

    assign pop       = valid_i & (count_q != '0);
    assign head_id   = tag_q[rptr_q];

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;

    always_comb begin
        tag_d     = tag_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        last_b_d  = last_b_q;
        err_d     = err_q;

        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        valid_d   = grant;

        a_rdata_d = a_rdata_q;
        a_rw_d    = a_rw_q;
        a_valid_d = 1'b0;
        b_rdata_d = b_rdata_q;
        b_rw_d    = b_rw_q;
        b_valid_d = 1'b0;

        if (grant) begin
            tag_d[wptr_q] = grant_b;
            wptr_d        = wptr_q + PW'(1);
            last_b_d      = grant_b;
            addr_d        = grant_b ? b_addr_i  : a_addr_i;
            wdata_d       = grant_b ? b_wdata_i : a_wdata_i;
            rw_d          = grant_b ? b_rw_i    : a_rw_i;
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
            if (head_id) begin
                b_rdata_d = rdata_i;
                b_rw_d    = rw_i;
                b_valid_d = 1'b1;
            end else begin
                a_rdata_d = rdata_i;
                a_rw_d    = rw_i;
                a_valid_d = 1'b1;
            end
        end

        // Orphan response: dropped, flagged until reset.
        if (valid_i && count_q == '0)
            err_d = 1'b1;

        unique case ({grant, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            last_b_q  <= 1'b1;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            valid_q   <= 1'b0;
            a_rdata_q <= '0;
            a_rw_q    <= 1'b0;
            a_valid_q <= 1'b0;
            b_rdata_q <= '0;
            b_rw_q    <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            last_b_q  <= last_b_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            valid_q   <= valid_d;
            a_rdata_q <= a_rdata_d;
            a_rw_q    <= a_rw_d;
            a_valid_q <= a_valid_d;
            b_rdata_q <= b_rdata_d;
            b_rw_q    <= b_rw_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign rw_o      = rw_q;
    assign valid_o   = valid_q;
    assign a_rdata_o = a_rdata_q;
    assign a_rw_o    = a_rw_q;
    assign a_valid_o = a_valid_q;
    assign b_rdata_o = b_rdata_q;
    assign b_rw_o    = b_rw_q;
    assign b_valid_o = b_valid_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter. A reference model (queue of
//   outstanding requester ids, last-winner flag, sticky error bit) predicts
//   ready and every registered output each cycle. A directed vector table,
//   hand-written corner sequences and a randomized phase drive the DUT.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [DW-1:0] a_wdata_i, b_wdata_i;
    logic          a_rw_i, a_valid_i, a_ready_o;
    logic          b_rw_i, b_valid_i, b_ready_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          rw_o, valid_o;
    logic [DW-1:0] rdata_i;
    logic          rw_i, valid_i;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic          a_rw_o, a_valid_o, b_rw_o, b_valid_o;
    logic          err_o;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rw_i(a_rw_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_rw_i(b_rw_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .a_rdata_o(a_rdata_o), .a_rw_o(a_rw_o), .a_valid_o(a_valid_o),
        .b_rdata_o(b_rdata_o), .b_rw_o(b_rw_o), .b_valid_o(b_valid_o),
        .err_o(err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int            mq[$];      // requester ids outstanding, oldest first
    bit            m_last_b;
    bit            m_ga, m_gb;
    bit            act_ardy, act_brdy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_ard, e_brd;
    logic          e_rw, e_vo, e_arw, e_av, e_brw, e_bv, e_err;

    // Pending request fields for each requester (held until granted)
    logic [AW-1:0] pa_addr, pb_addr;
    logic [DW-1:0] pa_wd, pb_wd;
    logic          pa_rw, pb_rw;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic          ar;
        logic          bv;
        logic [AW-1:0] ba;
        logic          br;
        logic          rv;
        logic [DW-1:0] rd;
        logic          e_ardy, e_brdy, e_vo, e_avo, e_bvo;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last_b = 1'b1;
        e_addr = '0; e_wd = '0; e_rw = 1'b0; e_vo = 1'b0;
        e_ard = '0; e_arw = 1'b0; e_av = 1'b0;
        e_brd = '0; e_brw = 1'b0; e_bv = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic check_outs();
        chk("valid_o", valid_o, e_vo);
        chk("addr_o", addr_o, e_addr);
        chk("wdata_o", wdata_o, e_wd);
        chk("rw_o", rw_o, e_rw);
        chk("a_valid_o", a_valid_o, e_av);
        chk("a_rdata_o", a_rdata_o, e_ard);
        chk("a_rw_o", a_rw_o, e_arw);
        chk("b_valid_o", b_valid_o, e_bv);
        chk("b_rdata_o", b_rdata_o, e_brd);
        chk("b_rw_o", b_rw_o, e_brw);
        chk("err_o", err_o, e_err);
    endtask

    task automatic new_a(); pa_addr = 16'($urandom); pa_wd = 16'($urandom); pa_rw = 1'($urandom); endtask
    task automatic new_b(); pb_addr = 16'($urandom); pb_wd = 16'($urandom); pb_rw = 1'($urandom); endtask

    // One clock cycle: drive, check ready against the model, advance the
    // model, clock, then check the registered outputs. Entered at posedge+1.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] aw, input logic ar,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bw, input logic br,
                        input logic rv, input logic [DW-1:0] rd, input logic rr);
        bit room;
        int id;
        a_valid_i = av; a_addr_i = aa; a_wdata_i = aw; a_rw_i = ar;
        b_valid_i = bv; b_addr_i = ba; b_wdata_i = bw; b_rw_i = br;
        valid_i = rv; rdata_i = rd; rw_i = rr;
        #1;
        room = (mq.size() < MAXO);
        m_ga = room && av && (!bv || m_last_b);
        m_gb = room && bv && (!av || !m_last_b);
        act_ardy = a_ready_o;
        act_brdy = b_ready_o;
        chk("a_ready_o", a_ready_o, m_ga);
        chk("b_ready_o", b_ready_o, m_gb);
        e_vo = m_ga || m_gb;
        if (m_ga) begin e_addr = aa; e_wd = aw; e_rw = ar; end
        if (m_gb) begin e_addr = ba; e_wd = bw; e_rw = br; end
        e_av = 1'b0;
        e_bv = 1'b0;
        if (rv) begin
            if (mq.size() > 0) begin
                id = mq.pop_front();
                if (id == 0) begin e_av = 1'b1; e_ard = rd; e_arw = rr; end
                else         begin e_bv = 1'b1; e_brd = rd; e_brw = rr; end
            end else begin
                e_err = 1'b1;
            end
        end
        if (m_ga) begin mq.push_back(0); m_last_b = 1'b0; end
        if (m_gb) begin mq.push_back(1); m_last_b = 1'b1; end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    // Step using the pending request fields; refresh whichever was granted.
    task automatic cyc(input logic av, input logic bv, input logic rv);
        step(av, pa_addr, pa_wd, pa_rw, bv, pb_addr, pb_wd, pb_rw,
             rv, 16'($urandom), 1'($urandom));
        if (m_ga) new_a();
        if (m_gb) new_b();
    endtask

    task automatic drain();
        for (int k = 0; k < MAXO + 1 && mq.size() > 0; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        a_valid_i = 1'b0; b_valid_i = 1'b0; valid_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ngr;
        // av  aa     ar  bv  ba     br  rv  rd       rdyA rdyB vo  avo bvo
        tbl[0] = '{1, 16'h0003, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 0};
        tbl[1] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0003, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 16'h0010, 1, 1, 16'h0020, 0, 0, 16'h0000, 0, 1, 1, 0, 0};
        tbl[5] = '{1, 16'h0010, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 0};
        tbl[6] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0055, 0, 0, 0, 0, 1};
        tbl[7] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0066, 0, 0, 0, 1, 0};
        tbl[8] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0};

        a_addr_i = '0; a_wdata_i = '0; a_rw_i = 1'b0;
        b_addr_i = '0; b_wdata_i = '0; b_rw_i = 1'b0;
        rdata_i = '0; rw_i = 1'b0;
        new_a(); new_b();

        // Reset state, then directed vectors (single read, tie, routing)
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].av, tbl[i].aa, tbl[i].aa + 16'h1111, tbl[i].ar,
                 tbl[i].bv, tbl[i].ba, tbl[i].ba + 16'h2222, tbl[i].br,
                 tbl[i].rv, tbl[i].rd, 1'b0);
            chk($sformatf("vec%0d_ardy", i), act_ardy, tbl[i].e_ardy);
            chk($sformatf("vec%0d_brdy", i), act_brdy, tbl[i].e_brdy);
            chk($sformatf("vec%0d_vo", i), valid_o, tbl[i].e_vo);
            chk($sformatf("vec%0d_avo", i), a_valid_o, tbl[i].e_avo);
            chk($sformatf("vec%0d_bvo", i), b_valid_o, tbl[i].e_bvo);
        end
        chk("vec_addr_hold", addr_o, 16'h0010);

        // Both held valid for 6 requests each: A,B,A,B... from reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, mq.size() > 0);
            chk($sformatf("alt_grant%0d", i), {act_ardy, act_brdy}, (i % 2) ? 2'b01 : 2'b10);
        end
        drain();

        // Stalled chain: exactly MAXO grants to A
        ngr = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            ngr += int'(act_ardy);
        end
        chk("stall_grants", ngr, MAXO);
        // Full + B request + response same cycle: nobody granted
        cyc(1'b1, 1'b1, 1'b1);
        chk("full_pop_no_grant", {act_ardy, act_brdy}, 2'b00);
        // Next cycle the freed slot goes to B (last winner was A)
        cyc(1'b1, 1'b1, 1'b0);
        chk("b_after_full", {act_ardy, act_brdy}, 2'b01);
        cyc(1'b1, 1'b0, 1'b1);
        chk("full_again", act_ardy, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("a_resumes", act_ardy, 1'b1);
        drain();

        // Orphan response sets sticky error
        cyc(1'b0, 1'b0, 1'b1);
        chk("orphan_no_avo", a_valid_o, 1'b0);
        chk("orphan_no_bvo", b_valid_o, 1'b0);
        chk("orphan_err", err_o, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, i[0], mq.size() > 0);
        drain();
        chk("err_sticky", err_o, 1'b1);

        // Asynchronous reset with 3 outstanding
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("three_outstanding", mq.size(), 3);
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid_o", valid_o, 1'b0);
        chk("async_addr_o", addr_o, '0);
        chk("async_wdata_o", wdata_o, '0);
        chk("async_a_valid_o", a_valid_o, 1'b0);
        chk("async_a_rdata_o", a_rdata_o, '0);
        chk("async_b_rdata_o", b_rdata_o, '0);
        chk("async_err_o", err_o, 1'b0);
        chk("async_a_ready_o", a_ready_o, 1'b0);
        chk("async_b_ready_o", b_ready_o, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        chk("late_resp_err", err_o, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_reset_grant", act_ardy, 1'b1);
        chk("post_reset_vo", valid_o, 1'b1);
        drain();

        // Randomized traffic against the model
        do_reset();
        begin
            bit av = 0, bv = 0;
            for (int i = 0; i < 400; i++) begin
                if (!av && ($urandom_range(0, 2) == 0)) av = 1;
                if (!bv && ($urandom_range(0, 2) == 0)) bv = 1;
                cyc(av, bv, (mq.size() > 0) && ($urandom_range(0, 2) != 0));
                if (m_ga) av = 0;
                if (m_gb) bv = 0;
            end
        end
        drain();
        chk("rand_no_err", err_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
